// File: rtl/digdug_inputs.sv
// digdug_inputs: conditions hps_io joystick words for the DigDug core's
// INP0/INP1 ports. It synchronises the inputs into the MCLK domain, merges
// player 2 into player 1 on an upright cabinet, and turns coin presses into
// frame-counted pulses with a lockout gap and a one-deep pending queue.
// Optional build macro: INP_FOURWAY_EN restricts each stick to 4-way motion.
module digdug_inputs #(
    parameter int unsigned COIN_FRAMES = 4,
    parameter int unsigned COIN_GAP    = 2
) (
    input  logic        MCLK,
    input  logic        RESET_N,
    input  logic [15:0] JOY1,
    input  logic [15:0] JOY2,
    input  logic        VBLK,
    input  logic        CABINET,
    input  logic        SERVICE,
    output logic [7:0]  INP0,
    output logic [7:0]  INP1
);

    localparam logic [3:0] PULSE_LEN = 4'(COIN_FRAMES);
    localparam logic [3:0] GAP_LEN   = 4'(COIN_GAP);

    typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_GAP} coin_state_e;

    // Stick nibble in INP1 order: {left, down, right, up}.
    function automatic logic [3:0] stick(input logic [7:0] j);
        return {j[1], j[2], j[0], j[3]};
    endfunction

    logic [7:0] j1_meta, j1_sync, j2_meta, j2_sync;
    logic       vblk_meta, vblk_sync, vblk_prev;
    logic       svc_meta, svc_sync;
    logic [1:0] coin_prev;

    // Upper joystick bits carry nothing the core uses.
    logic unused_joy_hi;
    assign unused_joy_hi = ^{JOY1[15:8], JOY2[15:8]};

    // Two-flop synchronisers, plus delayed copies of VBLK and the coins for edge detection.
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            j1_meta   <= '0;
            j1_sync   <= '0;
            j2_meta   <= '0;
            j2_sync   <= '0;
            vblk_meta <= 1'b0;
            vblk_sync <= 1'b0;
            vblk_prev <= 1'b0;
            svc_meta  <= 1'b0;
            svc_sync  <= 1'b0;
            coin_prev <= '0;
        end else begin
            // NOTE: non-blocking assignments make each stage capture the previous stage's old value, forming a real shift chain.
            j1_meta   <= JOY1[7:0];
            j1_sync   <= j1_meta;
            j2_meta   <= JOY2[7:0];
            j2_sync   <= j2_meta;
            vblk_meta <= VBLK;
            vblk_sync <= vblk_meta;
            vblk_prev <= vblk_sync;
            svc_meta  <= SERVICE;
            svc_sync  <= svc_meta;
            coin_prev <= {j2_sync[7], j1_sync[7]};
        end
    end

    logic       frame_tick;
    logic [1:0] coin_edge;
    assign frame_tick = vblk_sync & ~vblk_prev;
    assign coin_edge  = {j2_sync[7], j1_sync[7]} & ~coin_prev;

    logic [3:0] p1_dir, p2_dir, p1_out, p2_out;
    logic       p1_pump, p2_pump;

    // Upright cabinets share one control panel, so player 2 also drives player 1.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value unassigned and no latch is inferred.
        p1_dir  = stick(j1_sync);
        p1_pump = j1_sync[4];
        p2_dir  = stick(j2_sync);
        p2_pump = j2_sync[4];
        if (!CABINET) begin
            p1_dir  = stick(j1_sync | j2_sync);
            p1_pump = j1_sync[4] | j2_sync[4];
        end
    end

`ifdef INP_FOURWAY_EN
    // Axis activity with opposite pairs cancelled.
    function automatic logic vert_on(input logic [3:0] d);
        return d[2] ^ d[0];
    endfunction

    function automatic logic horz_on(input logic [3:0] d);
        return d[3] ^ d[1];
    endfunction

    // Newly active axis wins (vertical on a tie); otherwise keep the held axis.
    function automatic logic [3:0] four_way(input logic [3:0] d, input logic v_was,
                                            input logic h_was, input logic [3:0] held);
        logic [3:0] clean;
        logic       take_vert;
        clean = {d[3] & ~d[1], d[2] & ~d[0], d[1] & ~d[3], d[0] & ~d[2]};
        if (!v_was)
            take_vert = 1'b1;
        else if (!h_was)
            take_vert = 1'b0;
        else
            take_vert = ~(held[3] | held[1]);
        if (vert_on(d) && horz_on(d))
            return take_vert ? (clean & 4'b0101) : (clean & 4'b1010);
        return clean;
    endfunction

    logic [1:0] vert_prev, horz_prev;

    // Remember which axes were active last cycle to spot a newly pressed axis.
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            vert_prev <= '0;
            horz_prev <= '0;
        end else begin
            vert_prev <= {vert_on(p2_dir), vert_on(p1_dir)};
            horz_prev <= {horz_on(p2_dir), horz_on(p1_dir)};
        end
    end

    // Filter each stick, using the registered output as the held direction.
    always_comb begin
        p1_out = four_way(p1_dir, vert_prev[0], horz_prev[0], INP1[3:0]);
        p2_out = four_way(p2_dir, vert_prev[1], horz_prev[1], INP1[7:4]);
    end
`else
    assign p1_out = p1_dir;
    assign p2_out = p2_dir;
`endif

    logic [1:0] coin_active;

    for (genvar c = 0; c < 2; c++) begin : g_coin
        coin_state_e state;
        logic [3:0]  cnt;
        logic        pending;
        logic        exit_now;

        // A zero-length gap ends the window on the same tick that ends the pulse.
        assign exit_now = frame_tick && (cnt == 4'd1) &&
                          ((state == ST_GAP) || (state == ST_PULSE && GAP_LEN == 4'd0));
        assign coin_active[c] = (state == ST_PULSE);

        // Coin pulse shaper: pulse, lockout gap, then replay one queued press.
        always_ff @(posedge MCLK or negedge RESET_N) begin
            if (!RESET_N) begin
                state   <= ST_IDLE;
                cnt     <= '0;
                pending <= 1'b0;
            end else if (state == ST_IDLE) begin
                if (coin_edge[c]) begin
                    state <= ST_PULSE;
                    cnt   <= PULSE_LEN;
                end
            end else if (exit_now) begin
                pending <= 1'b0;
                if (pending || coin_edge[c]) begin
                    state <= ST_PULSE;
                    cnt   <= PULSE_LEN;
                end else begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            end else begin
                if (coin_edge[c])
                    pending <= 1'b1;
                if (frame_tick) begin
                    if (state == ST_PULSE && cnt == 4'd1) begin
                        state <= ST_GAP;
                        cnt   <= GAP_LEN;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
            end
        end
    end

    // Output registers feeding the core's input ports.
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            INP0 <= '0;
            INP1 <= '0;
        end else begin
            INP0 <= {svc_sync, 1'b0, coin_active[1], coin_active[0],
                     j1_sync[6] | j2_sync[6], j1_sync[5] | j2_sync[5], p2_pump, p1_pump};
            INP1 <= {p2_out, p1_out};
        end
    end

endmodule

// File: tb/tb_digdug_inputs.sv
// Bench for digdug_inputs: two instances (4/2 and 2/0 coin timing) share the
// inputs. Directed vectors and coin sequences use hand-derived expectations;
// a randomized phase compares both instances against a behavioural model.
module tb_digdug_inputs;

    localparam int F_A = 4, G_A = 2;
    localparam int F_B = 2, G_B = 0;

    logic        MCLK = 1'b0;
    logic        RESET_N;
    logic [15:0] JOY1, JOY2;
    logic        VBLK, CABINET, SERVICE;
    logic [7:0]  inp0_a, inp1_a, inp0_b, inp1_b;

    int n_checks = 0;
    int n_errors = 0;

    digdug_inputs #(.COIN_FRAMES(F_A), .COIN_GAP(G_A)) dut (
        .MCLK(MCLK), .RESET_N(RESET_N), .JOY1(JOY1), .JOY2(JOY2), .VBLK(VBLK),
        .CABINET(CABINET), .SERVICE(SERVICE), .INP0(inp0_a), .INP1(inp1_a)
    );

    digdug_inputs #(.COIN_FRAMES(F_B), .COIN_GAP(G_B)) dut_g0 (
        .MCLK(MCLK), .RESET_N(RESET_N), .JOY1(JOY1), .JOY2(JOY2), .VBLK(VBLK),
        .CABINET(CABINET), .SERVICE(SERVICE), .INP0(inp0_b), .INP1(inp1_b)
    );

    always #10 MCLK = ~MCLK;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1);
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct packed { logic [7:0] j1; logic [7:0] j2; logic vblk; logic svc; } in_t;
    // left = frame ticks remaining in the pulse+gap window; pulse is high while left > gap.
    typedef struct { int left; bit pend; } coin_m_t;
    typedef struct { bit pv; bit ph; logic [3:0] out; } fw_t;

    in_t        hist [4];
    coin_m_t    cm_a [2];
    coin_m_t    cm_b [2];
    fw_t        fw [2];
    logic [7:0] exp0_a, exp0_b, exp1;

    function automatic logic [3:0] stick_m(input logic [7:0] j);
        return {j[1], j[2], j[0], j[3]};   // {left, down, right, up}
    endfunction

    function automatic bit active(input coin_m_t m, input int g);
        return m.left > g;
    endfunction

    function automatic coin_m_t coin_step(input coin_m_t m, input bit e, input bit t,
                                          input int f, input int g);
        coin_m_t n = m;
        if (m.left == 0) begin
            if (e) n.left = f + g;          // a tick in the entry cycle is not counted
        end else begin
            if (e) n.pend = 1'b1;           // depth one: extra presses vanish
            if (t) begin
                n.left = m.left - 1;
                if (n.left == 0 && n.pend) begin
                    n.left = f + g;
                    n.pend = 1'b0;
                end
            end
        end
        return n;
    endfunction

    function automatic fw_t fw_step(input fw_t s, input logic [3:0] d);
        fw_t n;
        bit  up, dn, lf, rt, pick_vert;
        up = d[0] && !d[2];
        dn = d[2] && !d[0];
        rt = d[1] && !d[3];
        lf = d[3] && !d[1];
        n.pv = up || dn;
        n.ph = lf || rt;
        if (n.pv && n.ph) begin
            if (!s.pv)      pick_vert = 1'b1;
            else if (!s.ph) pick_vert = 1'b0;
            else            pick_vert = !(s.out[1] || s.out[3]);
            if (pick_vert) begin lf = 1'b0; rt = 1'b0; end
            else           begin up = 1'b0; dn = 1'b0; end
        end
        n.out = {lf, dn, rt, up};
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) hist[i] = '0;
        for (int i = 0; i < 2; i++) begin
            cm_a[i] = '{0, 1'b0};
            cm_b[i] = '{0, 1'b0};
            fw[i]   = '{1'b0, 1'b0, 4'h0};
        end
        exp0_a = '0;
        exp0_b = '0;
        exp1   = '0;
    endtask

    // One clock edge of the model: outputs reflect inputs from two edges earlier.
    task automatic model_step();
        in_t        cur, old;
        bit         tick;
        logic [3:0] d1, d2;
        logic       pump1, pump2, st1, st2;
        if (!RESET_N) begin
            model_reset();
            return;
        end
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = {JOY1[7:0], JOY2[7:0], VBLK, SERVICE};
        cur   = hist[2];
        old   = hist[3];
        tick  = cur.vblk && !old.vblk;
        d2    = stick_m(cur.j2);
        d1    = CABINET ? stick_m(cur.j1) : stick_m(cur.j1 | cur.j2);
        pump2 = cur.j2[4];
        pump1 = CABINET ? cur.j1[4] : (cur.j1[4] | cur.j2[4]);
        st1   = cur.j1[5] | cur.j2[5];
        st2   = cur.j1[6] | cur.j2[6];
`ifdef INP_FOURWAY_EN
        fw[0] = fw_step(fw[0], d1);
        fw[1] = fw_step(fw[1], d2);
        d1    = fw[0].out;
        d2    = fw[1].out;
`endif
        exp1   = {d2, d1};
        exp0_a = {cur.svc, 1'b0, active(cm_a[1], G_A), active(cm_a[0], G_A), st2, st1, pump2, pump1};
        exp0_b = {cur.svc, 1'b0, active(cm_b[1], G_B), active(cm_b[0], G_B), st2, st1, pump2, pump1};
        cm_a[0] = coin_step(cm_a[0], cur.j1[7] && !old.j1[7], tick, F_A, G_A);
        cm_a[1] = coin_step(cm_a[1], cur.j2[7] && !old.j2[7], tick, F_A, G_A);
        cm_b[0] = coin_step(cm_b[0], cur.j1[7] && !old.j1[7], tick, F_B, G_B);
        cm_b[1] = coin_step(cm_b[1], cur.j2[7] && !old.j2[7], tick, F_B, G_B);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic cycle();
        @(posedge MCLK);
        model_step();
        @(negedge MCLK);
    endtask

    task automatic wait_n(input int n);
        repeat (n) cycle();
    endtask

    task automatic press(input int ch);
        if (ch == 0) JOY1[7] = 1'b1; else JOY2[7] = 1'b1;
        wait_n(6);
        if (ch == 0) JOY1[7] = 1'b0; else JOY2[7] = 1'b0;
        wait_n(2);
    endtask

    // One frame tick, fully propagated to the outputs when this returns.
    task automatic frame();
        VBLK = 1'b1;
        wait_n(4);
        VBLK = 1'b0;
        wait_n(4);
    endtask

    typedef struct { logic [15:0] j1; logic [15:0] j2; logic cab; logic svc; logic [7:0] e0; logic [7:0] e1; } vec_t;
    vec_t vecs [14];

    initial begin
        vecs[0]  = '{16'h0008, 16'h0000, 1'b0, 1'b0, 8'h00, 8'h01};  // up1
        vecs[1]  = '{16'h0000, 16'h0002, 1'b0, 1'b0, 8'h00, 8'h88};  // P2 left, merged
        vecs[2]  = '{16'h0000, 16'h0002, 1'b1, 1'b0, 8'h00, 8'h80};  // P2 left, cocktail
        vecs[3]  = '{16'h0000, 16'h0004, 1'b0, 1'b0, 8'h00, 8'h44};  // P2 down, merged
        vecs[4]  = '{16'h0000, 16'h0004, 1'b1, 1'b0, 8'h00, 8'h40};  // P2 down, cocktail
        vecs[5]  = '{16'h0010, 16'h0000, 1'b0, 1'b0, 8'h01, 8'h00};  // pump1
        vecs[6]  = '{16'h0000, 16'h0010, 1'b0, 1'b0, 8'h03, 8'h00};  // P2 pump, merged
        vecs[7]  = '{16'h0000, 16'h0010, 1'b1, 1'b0, 8'h02, 8'h00};  // P2 pump, cocktail
        vecs[8]  = '{16'h0020, 16'h0000, 1'b0, 1'b0, 8'h04, 8'h00};  // start1
        vecs[9]  = '{16'h0000, 16'h0020, 1'b1, 1'b0, 8'h04, 8'h00};  // start1 from P2
        vecs[10] = '{16'h0040, 16'h0000, 1'b0, 1'b0, 8'h08, 8'h00};  // start2
        vecs[11] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 8'h80, 8'h00};  // service
        vecs[12] = '{16'hFF00, 16'hFF00, 1'b0, 1'b0, 8'h00, 8'h00};  // upper bits ignored
        vecs[13] = '{16'h0001, 16'h0001, 1'b1, 1'b0, 8'h00, 8'h22};  // right1, right2

        RESET_N = 1'b0;
        JOY1 = '0; JOY2 = '0; VBLK = 1'b0; CABINET = 1'b0; SERVICE = 1'b0;
        model_reset();
        wait_n(3);
        RESET_N = 1'b1;
        wait_n(3);
        check("reset_inp0", inp0_a, 8'h00);
        check("reset_inp1", inp1_a, 8'h00);

        // Direction latency: three clocks from input to output.
        JOY1 = 16'h0008;
        wait_n(2);
        check("dir_lat2", inp1_a, 8'h00);
        wait_n(1);
        check("dir_lat3", inp1_a, 8'h01);

        for (int i = 0; i < 14; i++) begin
            JOY1 = vecs[i].j1; JOY2 = vecs[i].j2; CABINET = vecs[i].cab; SERVICE = vecs[i].svc;
            wait_n(4);
            check($sformatf("vec%0d_inp0", i), inp0_a, vecs[i].e0);
            check($sformatf("vec%0d_inp1", i), inp1_a, vecs[i].e1);
        end

        // Four-way filter (or pass-through) on player 1 alone.
        JOY1 = '0; JOY2 = '0; CABINET = 1'b1; SERVICE = 1'b0;
        wait_n(4);
`ifdef INP_FOURWAY_EN
        JOY1 = 16'h0008; wait_n(4); check("fw_up",          {4'h0, inp1_a[3:0]}, 8'h01);
        JOY1 = 16'h0009; wait_n(4); check("fw_up_add_right", {4'h0, inp1_a[3:0]}, 8'h02);
        JOY1 = 16'h0008; wait_n(4); check("fw_release_right", {4'h0, inp1_a[3:0]}, 8'h01);
        JOY1 = 16'h0000; wait_n(4);
        JOY1 = 16'h0009; wait_n(4); check("fw_diag_together", {4'h0, inp1_a[3:0]}, 8'h01);
        JOY1 = 16'h0000; wait_n(4);
        JOY1 = 16'h000C; wait_n(4); check("fw_up_down",       {4'h0, inp1_a[3:0]}, 8'h00);
        JOY1 = 16'h000D; wait_n(4); check("fw_up_down_right", {4'h0, inp1_a[3:0]}, 8'h02);
`else
        JOY1 = 16'h0009; wait_n(4); check("pass_diag",    {4'h0, inp1_a[3:0]}, 8'h03);
        JOY1 = 16'h000C; wait_n(4); check("pass_up_down", {4'h0, inp1_a[3:0]}, 8'h05);
`endif
        JOY1 = '0; CABINET = 1'b0;
        wait_n(4);

        // Coin 1: latency, pulse length, one queued press, a dropped third press.
        JOY1[7] = 1'b1;
        wait_n(3); check("coin1_lat3", {7'h0, inp0_a[4]}, 8'h00);
        wait_n(1); check("coin1_lat4", {7'h0, inp0_a[4]}, 8'h01);
        wait_n(2); JOY1[7] = 1'b0; wait_n(2);
        frame(); check("coin1_t1", {7'h0, inp0_a[4]}, 8'h01);
        press(0);
        frame(); check("coin1_t2", {7'h0, inp0_a[4]}, 8'h01);
        press(0);
        frame(); check("coin1_t3", {7'h0, inp0_a[4]}, 8'h01);
        frame(); check("coin1_t4_gap", {7'h0, inp0_a[4]}, 8'h00);
        frame(); check("coin1_t5_gap", {7'h0, inp0_a[4]}, 8'h00);
        frame(); check("coin1_t6_second", {7'h0, inp0_a[4]}, 8'h01);
        frame(); frame();
        frame(); check("coin1_t9_second", {7'h0, inp0_a[4]}, 8'h01);
        frame(); check("coin1_t10_end", {7'h0, inp0_a[4]}, 8'h00);
        frame(); frame(); check("coin1_t12_idle", {7'h0, inp0_a[4]}, 8'h00);
        frame(); frame(); check("coin1_no_third", {7'h0, inp0_a[4]}, 8'h00);

        // Coin edge and frame tick in the same cycle: that tick is not counted.
        JOY1[7] = 1'b1; VBLK = 1'b1;
        wait_n(4); check("coin1_edge_tick", {7'h0, inp0_a[4]}, 8'h01);
        JOY1[7] = 1'b0; VBLK = 1'b0;
        wait_n(4);
        frame(); frame();
        frame(); check("coin1_et_t3", {7'h0, inp0_a[4]}, 8'h01);
        frame(); check("coin1_et_t4", {7'h0, inp0_a[4]}, 8'h00);
        frame(); frame();

        // Coin 2 on the zero-gap instance: queued press gives back-to-back pulses.
        press(1);
        check("g0_coin2_start", {7'h0, inp0_b[5]}, 8'h01);
        press(1);
        frame();
        check("g0_coin2_t1", {7'h0, inp0_b[5]}, 8'h01);
        check("g0_coin1_idle", {7'h0, inp0_b[4]}, 8'h00);
        VBLK = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) VBLK = 1'b0;
            cycle();
            check($sformatf("g0_coin2_join%0d", i), {7'h0, inp0_b[5]}, 8'h01);
        end
        frame(); check("g0_coin2_t3", {7'h0, inp0_b[5]}, 8'h01);
        frame(); check("g0_coin2_t4_end", {7'h0, inp0_b[5]}, 8'h00);

        // Reset in the middle of a coin pulse.
        press(0);
        check("rst_pulse_on", {7'h0, inp0_a[4]}, 8'h01);
        frame();
        #2 RESET_N = 1'b0;
        #1;
        check("rst_async_inp0", inp0_a, 8'h00);
        check("rst_async_inp1", inp1_a, 8'h00);
        cycle();
        RESET_N = 1'b1;
        frame(); check("rst_after1", {7'h0, inp0_a[4]}, 8'h00);
        frame(); frame(); check("rst_after3", {7'h0, inp0_a[4]}, 8'h00);

        // Randomized traffic on both instances against the model.
        for (int blk = 0; blk < 2; blk++) begin
            CABINET = (blk == 1);
            for (int n = 0; n < 1500; n++) begin
                if ($urandom_range(0, 7) == 0) JOY1 = 16'($urandom());
                if ($urandom_range(0, 7) == 0) JOY2 = 16'($urandom());
                if ($urandom_range(0, 31) == 0) SERVICE = ~SERVICE;
                if ($urandom_range(0, 15) == 0) VBLK = ~VBLK;
                cycle();
                check("rand_a_inp0", inp0_a, exp0_a);
                check("rand_a_inp1", inp1_a, exp1);
                check("rand_b_inp0", inp0_b, exp0_b);
                check("rand_b_inp1", inp1_b, exp1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
